// File: rtl/mult_pkg.sv
//------------------------------------------------------------------------------
// Module   : mult_pkg
// Brief    : Shared state encoding and defaults for the sequential multiplier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  localparam int c_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Counter width able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_dp.sv
//------------------------------------------------------------------------------
// Module   : seq_mult_dp
// Brief    : Shift-and-add datapath: magnitude load, accumulate, sign fix-up.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_mult_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 fix_i,
  input  logic                 is_signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 bzero_o,
  output logic [2*WIDTH-1:0]   product_o
);

  logic [2*WIDTH-1:0] a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  // Most-negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
  always_comb begin
    w_a_mag = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    w_b_mag = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;

    if (load_i) begin
      a_d   = {{WIDTH{1'b0}}, w_a_mag};
      b_d   = w_b_mag;
      acc_d = '0;
      neg_d = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (step_i) begin
      if (b_q[0]) begin
        acc_d = acc_q + a_q;
      end
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end

    if (fix_i) begin
      product_d = neg_q ? -acc_q : acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Looks one step ahead: true when B will be zero after the current shift.
  assign bzero_o   = ~|b_q[WIDTH-1:1];
  assign product_o = product_q;

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
//------------------------------------------------------------------------------
// Module   : seq_multiplier
// Brief    : Sequential signed/unsigned multiplier with early termination.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int                 c_CNT_W     = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic               w_bzero;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_fix   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          w_load  = 1'b1;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        w_step  = 1'b1;
        count_d = count_q + c_CNT_W'(1);
        if (w_bzero || (count_q == c_LAST_STEP)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        w_fix   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  seq_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (w_load),
    .step_i      (w_step),
    .fix_i       (w_fix),
    .is_signed_i (is_signed),
    .a_i         (a_in),
    .b_i         (b_in),
    .bzero_o     (w_bzero),
    .product_o   (product)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_multiplier
// Brief    : Self-checking bench for seq_multiplier at WIDTH=16.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks = 0;
  int n_errors = 0;

  seq_multiplier #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input bit s, input logic [15:0] a, input logic [15:0] b);
    longint x, y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return 32'(x * y);
  endfunction

  // Cycle k ends on edge k; the accepting edge closes cycle 0.
  function automatic int ref_latency(input bit s, input logic [15:0] b);
    logic [15:0] mag;
    int          n;
    mag = (s && b[15]) ? -b : b;
    n   = 1;
    for (int i = 0; i < 16; i++) begin
      if (mag[i]) n = i + 1;
    end
    return n + 2;
  endfunction

  // Entered and left at posedge+1; the next call can start back-to-back.
  task automatic run_op(input bit s, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input int exp_lat,
                        input bit pulse_en, input string tag);
    int          edges;
    bit          early_change;
    logic [31:0] prev_p;
    prev_p    = product;
    start     = 1'b1;
    is_signed = s;
    a_in      = a;
    b_in      = b;
    @(posedge clk); #1;
    start     = 1'b0;
    is_signed = 1'($urandom);
    a_in      = 16'($urandom);
    b_in      = 16'($urandom);
    check({tag, " busy_after_start"}, 64'(busy), 64'(1));
    edges        = 0;
    early_change = 1'b0;
    while (!done && edges < 40) begin
      if (product !== prev_p) early_change = 1'b1;
      if (pulse_en) begin
        start     = 1'($urandom);
        is_signed = 1'($urandom);
        a_in      = 16'($urandom);
        b_in      = 16'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    start = pulse_en;
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " latency"}, 64'(edges + 1), 64'(exp_lat));
    check({tag, " product"}, 64'(product), 64'(exp_p));
    check({tag, " product_stable_before_done"}, 64'(early_change), 64'(0));
    check({tag, " busy_at_done"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " done_one_cycle"}, 64'(done), 64'(0));
    check({tag, " idle_after_done"}, 64'(busy), 64'(0));
    check({tag, " product_held"}, 64'(product), 64'(exp_p));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          s;
    logic [15:0] a, b;
    int          done_seen;

    rst_n     = 1'b0;
    start     = 1'b1;
    is_signed = 1'b0;
    a_in      = 16'h1234;
    b_in      = 16'h0003;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset product", 64'(product), 64'(0));

    // First edge with rst_n high accepts the start.
    rst_n = 1'b1;
    run_op(1'b0, 16'd17,   16'd5,    32'd85,         5,  1'b0, "u17x5");
    run_op(1'b1, 16'hFFFD, 16'd7,    32'hFFFFFFEB,   5,  1'b0, "sm3x7");
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001,   18, 1'b0, "umax");
    run_op(1'b1, 16'h8000, 16'h8000, 32'h40000000,   18, 1'b0, "sminsq");
    run_op(1'b0, 16'h1234, 16'h0000, 32'h00000000,   3,  1'b1, "ubzero");
    run_op(1'b0, 16'h0003, 16'h0100, 32'h00000300,   11, 1'b1, "ubusy_pulse");
    run_op(1'b1, 16'h0007, 16'hFFFF, 32'hFFFFFFF9,   3,  1'b0, "s7xm1");
    run_op(1'b1, 16'h8000, 16'h0001, 32'hFFFF8000,   3,  1'b0, "sminx1");
    run_op(1'b1, 16'h0000, 16'hFFFB, 32'h00000000,   5,  1'b0, "s0xm5");
    run_op(1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE,   4,  1'b1, "umaxx2");

    // Reset sampled low on edge 3 of a long operation.
    start     = 1'b1;
    is_signed = 1'b0;
    a_in      = 16'hFFFF;
    b_in      = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort busy_after_start", 64'(busy), 64'(1));
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort product", 64'(product), 64'(0));
    rst_n     = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort no_done", 64'(done_seen), 64'(0));
    check("abort stays_idle", 64'(busy), 64'(0));
    run_op(1'b0, 16'd17, 16'd5, 32'd85, 5, 1'b0, "after_abort");

    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 16);
      run_op(s, a, b, ref_prod(s, a, b), ref_latency(s, b), 1'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, legal range 4..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset: synchronous, active-low, sampled on the rising edge of clk.
REQ-004 start  input  1  request a multiplication; honoured only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 a_in  input  WIDTH  multiplicand, sampled on the accepted start edge.
REQ-007 b_in  input  WIDTH  multiplier, sampled on the accepted start edge.
REQ-008 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-009 done  output  1  one-cycle pulse; product is valid in that cycle.
REQ-010 product  output  2*WIDTH  result; holds its value until the next accepted start.

Function
REQ-011 States SHALL be IDLE, CALC, FIX and DONE; reset and all illegal encodings SHALL go to IDLE.
REQ-012 IDLE: start=1 SHALL load the operands as magnitudes, register the sign flag, clear the accumulator, clear the bit counter and go to CALC.
REQ-013 Magnitudes: |x| = -x when is_signed=1 and x[WIDTH-1]=1, otherwise x; treated as unsigned WIDTH bits, so the most-negative value maps to 2^(WIDTH-1).
REQ-014 Sign flag = is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]).
REQ-015 CALC step, once per cycle: if B[0]=1, acc += A (2*WIDTH-bit add, no overflow possible); then A <<= 1, B >>= 1, count += 1.
REQ-016 CALC SHALL perform at least one step and SHALL exit to FIX after the step in which the shifted B becomes 0 or count reaches WIDTH (early termination).
REQ-017 FIX SHALL write product = sign ? -acc : acc (2*WIDTH-bit two's complement) and go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, deassert busy and return to IDLE.
REQ-019 Latency: with N = max(1, position of the highest set bit of |b| + 1), done SHALL be high in cycle N+2 counted from the accepted start edge (cycle 0).
REQ-020 start while busy=1 or in DONE SHALL be ignored, and the operands SHALL NOT be re-sampled.
REQ-021 start asserted in the IDLE cycle right after DONE SHALL be accepted; back-to-back operation is legal.
REQ-022 product SHALL change only in FIX; a_in, b_in and is_signed changes after acceptance SHALL have no effect.

Reset
REQ-023 While rst_n=0 at a clock edge: state SHALL become IDLE, and busy, done and product SHALL become 0.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-025 The first start SHALL be accepted on the first edge at which rst_n=1.

Structure
REQ-026 Package mult_pkg SHALL hold the state enum (IDLE, CALC, FIX, DONE) and the default WIDTH constant.
REQ-027 The block SHALL be split into a controller (FSM and counter) and one sub-module, seq_mult_dp, holding the A, B and acc registers, the adder, the shifters and the B==0 detect.
REQ-028 The controller and datapath SHALL communicate only through load, step, fix and bzero signals.

Verification
REQ-029 WIDTH=16, unsigned, a=17, b=5, start at cycle 0 -> product=85 and done high at cycle 5 (N=3).
REQ-030 Signed, a=16'hFFFD (-3), b=7 -> product=32'hFFFFFFEB (-21) and done at cycle 5.
REQ-031 Unsigned, a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001 and done at cycle 18; signed, a=b=16'h8000 -> product=32'h40000000.
REQ-032 b=0, any a -> product=0 and done at cycle 3; start pulses during busy -> ignored, result unchanged.
REQ-033 rst_n=0 at cycle 3 of an operation -> state IDLE, busy=0, product=0 and no done; a new start after reset completes correctly.
REQ-034 Random regression: 1000 operands in both modes and in back-to-back runs -> product matches the reference model and latency matches REQ-019.
